// File: rtl/four_bit_universal_counter.sv
// 4-bit synchronous up-counter with parallel load, count enable and cascadable carry-out.
// Define UCNT_REG_COUT_EN for a registered one-cycle wrap flag on cout instead of combinational.
module four_bit_universal_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] acount,
  output logic             cout,
  input  logic             count,
  input  logic             load,
  input  logic             reset,
  input  logic             clk
);

  localparam logic [WIDTH-1:0] MaxCount = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] OneCount = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_acount;
  logic [WIDTH-1:0] w_acount_d;
  logic             w_at_max;
  logic             w_wrap;

  assign w_at_max = (r_acount == MaxCount);
  // Next edge will roll over to zero; load always overrides counting.
  assign w_wrap   = count & ~load & w_at_max;

  always_comb begin
    w_acount_d = r_acount;
    if (load) begin
      w_acount_d = din;
    end else if (count) begin
      w_acount_d = r_acount + OneCount;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_acount <= '0;
    end else begin
      r_acount <= w_acount_d;
    end
  end

  assign acount = r_acount;

`ifdef UCNT_REG_COUT_EN
  logic r_cout;

  // High only in the cycle after the max->0 wrap; any load or idle edge clears it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cout <= 1'b0;
    end else begin
      r_cout <= w_wrap;
    end
  end

  assign cout = r_cout;
`else
  assign cout = reset & w_wrap;
`endif

endmodule

// File: tb/tb_four_bit_universal_counter.sv
// Scoreboard bench for four_bit_universal_counter; honours UCNT_REG_COUT_EN for cout expectations.
module tb_four_bit_universal_counter;

  localparam int unsigned WIDTH = 4;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic             c;
    string            name;
  } exp_t;

  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] acount;
  logic             cout;
  logic             count;
  logic             load;
  logic             reset;
  logic             clk;

  exp_t q_sync[$];
  exp_t q_async[$];
  event async_ev;
  int   total;
  int   bad;

  four_bit_universal_counter #(.WIDTH(WIDTH)) dut (
    .din   (din),
    .acount(acount),
    .cout  (cout),
    .count (count),
    .load  (load),
    .reset (reset),
    .clk   (clk)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic compare(input exp_t e);
    total++;
    if (acount !== e.a || cout !== e.c) begin
      bad++;
      $display("FAIL %s: got acount=%h cout=%b, want acount=%h cout=%b at t=%0t",
               e.name, acount, cout, e.a, e.c, $time);
    end
  endtask

  // Registered-output monitor: one expectation consumed per rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (q_sync.size() != 0) begin
        e = q_sync.pop_front();
        compare(e);
      end
    end
  end

  // Immediate-response monitor for asynchronous clear checks.
  initial begin
    exp_t e;
    forever begin
      @(async_ev);
      while (q_async.size() != 0) begin
        e = q_async.pop_front();
        compare(e);
      end
    end
  end

  task automatic push_sync(input logic [WIDTH-1:0] a, input logic c, input string name);
    exp_t e;
    e.a = a;
    e.c = c;
    e.name = name;
    q_sync.push_back(e);
  endtask

  task automatic check_now(input logic [WIDTH-1:0] a, input logic c, input string name);
    exp_t e;
    e.a = a;
    e.c = c;
    e.name = name;
    q_async.push_back(e);
    ->async_ev;
    #0;
  endtask

  // Drive inputs on the falling edge; expectation is the state after the next rising edge.
  task automatic drive(input logic l, input logic c, input logic [WIDTH-1:0] d,
                       input logic [WIDTH-1:0] ea, input logic ec, input string name);
    @(negedge clk);
    load  = l;
    count = c;
    din   = d;
    push_sync(ea, ec, name);
  endtask

  initial begin
    logic [WIDTH-1:0] na;
    logic             ec;
    total = 0;
    bad   = 0;
    reset = 1'b0;
    load  = 1'b0;
    count = 1'b0;
    din   = '0;

    #3;
    check_now(4'h0, 1'b0, "reset_init");
    @(negedge clk);
    reset = 1'b1;

    // Full count cycle from 0 through wrap.
    for (int i = 0; i < 16; i++) begin
      na = 4'(i + 1);
`ifdef UCNT_REG_COUT_EN
      ec = (i == 15);
`else
      ec = (na == 4'hF);
`endif
      drive(1'b0, 1'b1, 4'h0, na, ec, "count_seq");
    end

    // Load wins over count.
    drive(1'b1, 1'b1, 4'hA, 4'hA, 1'b0, "load_over_count");
    drive(1'b1, 1'b1, 4'hF, 4'hF, 1'b0, "load_max_with_count");
    drive(1'b0, 1'b0, 4'h0, 4'hF, 1'b0, "hold_at_max");
`ifdef UCNT_REG_COUT_EN
    drive(1'b0, 1'b1, 4'h0, 4'h0, 1'b1, "wrap_from_hold");
`else
    drive(1'b0, 1'b1, 4'h0, 4'h0, 1'b0, "wrap_from_hold");
`endif
    drive(1'b1, 1'b0, 4'h6, 4'h6, 1'b0, "load_clears");

    // Hold for 10 edges.
    drive(1'b1, 1'b0, 4'h5, 4'h5, 1'b0, "load_5");
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b0, 4'h0, 4'h5, 1'b0, "hold_5");
    end

    // Async clear between edges at acount=7.
    drive(1'b1, 1'b0, 4'h7, 4'h7, 1'b0, "load_7");
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check_now(4'h0, 1'b0, "async_clear_7");
    @(negedge clk);
    reset = 1'b1;
    load  = 1'b0;
    count = 1'b0;
    push_sync(4'h0, 1'b0, "release_hold");

    // Reset pulse while counting at 3, then first increment after release.
    drive(1'b1, 1'b0, 4'h2, 4'h2, 1'b0, "load_2");
    drive(1'b0, 1'b1, 4'h0, 4'h3, 1'b0, "count_to_3");
    @(negedge clk);
    #1;
    reset = 1'b0;
    #1;
    check_now(4'h0, 1'b0, "pulse_clear_3");
    #1;
    reset = 1'b1;
    push_sync(4'h1, 1'b0, "first_after_release");

    // Reset held across an edge discards a pending load.
    @(negedge clk);
    load  = 1'b1;
    count = 1'b1;
    din   = 4'h9;
    #1;
    reset = 1'b0;
    #1;
    check_now(4'h0, 1'b0, "clear_mid_load");
    @(posedge clk);
    #2;
    check_now(4'h0, 1'b0, "held_in_reset");
    @(negedge clk);
    reset = 1'b1;
    load  = 1'b0;
    count = 1'b0;
    push_sync(4'h0, 1'b0, "load_discarded");

    // Wrap sequence from E.
    drive(1'b1, 1'b0, 4'hE, 4'hE, 1'b0, "load_E");
`ifdef UCNT_REG_COUT_EN
    drive(1'b0, 1'b1, 4'h0, 4'hF, 1'b0, "wrap_e1");
    drive(1'b0, 1'b1, 4'h0, 4'h0, 1'b1, "wrap_e2");
    drive(1'b0, 1'b1, 4'h0, 4'h1, 1'b0, "wrap_e3");
`else
    drive(1'b0, 1'b1, 4'h0, 4'hF, 1'b1, "wrap_e1");
    drive(1'b0, 1'b1, 4'h0, 4'h0, 1'b0, "wrap_e2");
    drive(1'b0, 1'b1, 4'h0, 4'h1, 1'b0, "wrap_e3");
`endif

    // Drain the scoreboard within a bounded number of edges.
    for (int i = 0; i < 5; i++) begin
      if (q_sync.size() != 0) begin
        @(posedge clk);
        #3;
      end
    end
    if (q_sync.size() != 0 || q_async.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: pending sync=%0d async=%0d, want 0", q_sync.size(), q_async.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
